rr_stream_arbiter: RTL and testbench

//   Shares one registered valid/ready output channel among N_REQ valid/ready requesters.

---
 rtl/rr_stream_arbiter_if.sv | 43 ++++
 rtl/rr_stream_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_stream_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_arbiter_if
// Brief    : Requester-side and output-side handshake bundle for rr_stream_arbiter.
//            in_last/out_last exist only when RR_ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_stream_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = 2
);
    logic [N_REQ-1:0]       in_valid;
    logic [N_REQ*WIDTH-1:0] in_data;
    logic [N_REQ-1:0]       in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SRC_W-1:0]       out_src;
    logic                   out_ready;
`ifdef RR_ARB_LOCK_EN
    logic [N_REQ-1:0]       in_last;
    logic                   out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_src, out_last
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_src, out_last
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_arbiter
// Brief    : Round-robin arbiter sharing one registered valid/ready output among
//            N_REQ requesters. Define RR_ARB_LOCK_EN for packet-locked grants.
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rr_stream_arbiter_if.slave bus
);
    localparam logic [SRC_W:0]   c_n_req = (SRC_W+1)'(N_REQ);
    localparam logic [SRC_W-1:0] c_last_idx = SRC_W'(N_REQ-1);

    logic [SRC_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SRC_W-1:0] r_out_src;

    logic                    w_load;
    logic                    w_found;
    logic                    w_xfer;
    logic [SRC_W-1:0]        w_grant_idx;
    logic [SRC_W-1:0]        w_next_ptr;
    logic [WIDTH-1:0]        w_beat;
    logic [N_REQ-1:0]        w_ready;
    logic [SRC_W:0]          w_cand_sum [N_REQ];
    logic [SRC_W-1:0]        w_cand     [N_REQ];

`ifdef RR_ARB_LOCK_EN
    logic r_lock;
    logic r_out_last;
    logic w_beat_last;
`endif

    assign w_load = ~r_out_valid | bus.out_ready;

    // Candidate k is the requester k places after the pointer, wrapped mod N_REQ.
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        assign w_cand_sum[k] = {1'b0, r_ptr} + (SRC_W+1)'(k);
        assign w_cand[k]     = (w_cand_sum[k] >= c_n_req) ? SRC_W'(w_cand_sum[k] - c_n_req)
                                                          : SRC_W'(w_cand_sum[k]);
    end

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
`ifdef RR_ARB_LOCK_EN
        if (r_lock) begin
            w_found     = bus.in_valid[r_ptr];
            w_grant_idx = r_ptr;
        end else
`endif
        begin
            // Scan farthest-first so the candidate nearest the pointer wins.
            for (int k = N_REQ-1; k >= 0; k--) begin
                if (bus.in_valid[w_cand[k]]) begin
                    w_found     = 1'b1;
                    w_grant_idx = w_cand[k];
                end
            end
        end
    end

    always_comb begin
        w_beat  = '0;
        w_ready = '0;
`ifdef RR_ARB_LOCK_EN
        w_beat_last = 1'b0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == SRC_W'(i)) begin
                w_beat     = bus.in_data[i*WIDTH +: WIDTH];
                w_ready[i] = rst & w_load & w_found;
`ifdef RR_ARB_LOCK_EN
                w_beat_last = bus.in_last[i];
`endif
            end
        end
    end

    assign w_xfer     = rst & w_load & w_found;
    assign w_next_ptr = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + SRC_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
`ifdef RR_ARB_LOCK_EN
            r_lock      <= 1'b0;
            r_out_last  <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat;
            r_out_src   <= w_grant_idx;
`ifdef RR_ARB_LOCK_EN
            r_out_last  <= w_beat_last;
            // Mid-packet beats pin the pointer to the current owner.
            if (w_beat_last) begin
                r_lock <= 1'b0;
                r_ptr  <= w_next_ptr;
            end else begin
                r_lock <= 1'b1;
                r_ptr  <= w_grant_idx;
            end
`else
            r_ptr       <= w_next_ptr;
`endif
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
`ifdef RR_ARB_LOCK_EN
    assign bus.out_last  = r_out_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_arbiter
// Brief    : Directed scoreboard bench for rr_stream_arbiter (N_REQ=4, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int SRC_W = 2;

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rr_stream_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SRC_W(SRC_W)) bus ();

    rr_stream_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SRC_W(SRC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int src, input logic [7:0] data, input logic last);
        exp_t e;
        e.src  = SRC_W'(src);
        e.data = data;
        e.last = last;
        q.push_back(e);
    endtask

    // Monitor: a beat leaves on the next posedge whenever valid & ready here.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got src %0d data %0h required none", bus.out_src, bus.out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("beat_src", 32'(bus.out_src), 32'(e.src));
                check("beat_data", 32'(bus.out_data), 32'(e.data));
`ifdef RR_ARB_LOCK_EN
                check("beat_last", 32'(bus.out_last), 32'(e.last));
`endif
            end
        end
    end

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.out_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
        bus.in_last   = '1;
`endif
        // Reset with all requesters valid
        bus.in_valid = 4'hF;
        cyc();
        cyc();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b1;
        #1;
        check("first_grant", 32'(bus.in_ready), 32'h1);

        // Round robin over all four
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        push(0, 8'hA0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("rr_no_bubble", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = '0;
        cyc();
        check("rr_drained", 32'(bus.out_valid), 32'd0);

        // Single requester back-to-back
        push(2, 8'h21, 1'b1);
        push(2, 8'h22, 1'b1);
        push(2, 8'h23, 1'b1);
        bus.in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            bus.in_data[2*WIDTH +: WIDTH] = 8'(8'h21 + k);
            cyc();
            check("single_no_bubble", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = '0;
        cyc();

        // Stall then simultaneous drain and load
        push(1, 8'h41, 1'b1);
        push(1, 8'h42, 1'b1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        bus.in_data[1*WIDTH +: WIDTH] = 8'h41;
        cyc();
        bus.in_data[1*WIDTH +: WIDTH] = 8'h42;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_data", 32'(bus.out_data), 32'h41);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc();
        check("swap_valid", 32'(bus.out_valid), 32'd1);
        check("swap_data", 32'(bus.out_data), 32'h42);
        bus.in_valid = '0;
        cyc();

        // Async reset while a beat is held
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1000;
        bus.in_data[3*WIDTH +: WIDTH] = 8'h5C;
        cyc();
        bus.in_valid = '0;
        check("pre_rst_data", 32'(bus.out_data), 32'h5C);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_data", 32'(bus.out_data), 32'd0);
        cyc();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'hF;
        #1;
        check("ptr_restart", 32'(bus.in_ready), 32'h1);
        push(0, 8'hA0, 1'b1);
        cyc();
        bus.in_valid = '0;
        cyc();

`ifdef RR_ARB_LOCK_EN
        // Packet from req 1 holds the grant against req 0 and req 2
        bus.in_data[2*WIDTH +: WIDTH] = 8'h24;
        push(1, 8'h61, 1'b0);
        push(1, 8'h62, 1'b0);
        push(1, 8'h63, 1'b1);
        push(2, 8'h24, 1'b1);
        push(0, 8'hA0, 1'b1);
        bus.in_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            bus.in_data[1*WIDTH +: WIDTH] = 8'(8'h61 + k);
            bus.in_last[1] = (k == 2);
            cyc();
        end
        bus.in_valid = 4'b0101;
        cyc();
        bus.in_valid = 4'b0001;
        cyc();
        bus.in_valid = '0;
        cyc();
`endif

        for (int k = 0; k < 20 && q.size() != 0; k++) cyc();
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
